// File: rtl/dram_write_packer.sv
// rtl/dram_write_packer.sv - row FIFO that streams scratchpad rows to DRAM as strobed beats
module dram_write_packer #(
   parameter int NUM_COLS        = 32,
   parameter int ELEM_WIDTH      = 16,
   parameter int BEAT_ELEMS      = 4,
   parameter int DRAM_ADDR_WIDTH = 32,
   parameter int DEPTH           = 2,
   parameter int SKIP_EMPTY      = 1
) (
   input  logic                               clk,
   input  logic                               n_rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [NUM_COLS*ELEM_WIDTH-1:0]     in_row_data,
   input  logic [NUM_COLS-1:0]                in_col_mask,
   input  logic [DRAM_ADDR_WIDTH-1:0]         in_dram_addr,
   output logic                               dram_wvalid,
   input  logic                               dram_wready,
   output logic [DRAM_ADDR_WIDTH-1:0]         dram_waddr,
   output logic [BEAT_ELEMS*ELEM_WIDTH-1:0]   dram_wdata,
   output logic [BEAT_ELEMS-1:0]              dram_wstrb,
   output logic                               dram_wlast,
   output logic                               row_done,
   output logic [$clog2(DEPTH+1)-1:0]         occupancy,
   output logic                               busy
);

   localparam int NUM_BEATS  = NUM_COLS / BEAT_ELEMS;
   localparam int BEAT_BYTES = BEAT_ELEMS * ELEM_WIDTH / 8;
   localparam int ROW_BYTES  = NUM_COLS * ELEM_WIDTH / 8;
   localparam int ROW_W      = NUM_COLS * ELEM_WIDTH;
   localparam int BEAT_DW    = BEAT_ELEMS * ELEM_WIDTH;
   localparam int BEAT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W      = $clog2(DEPTH + 1);
   localparam logic [DRAM_ADDR_WIDTH-1:0] ALIGN_MASK = ~DRAM_ADDR_WIDTH'(ROW_BYTES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EMPTY_ROW} state_t;

   logic [ROW_W-1:0]           data_mem [DEPTH];
   logic [NUM_COLS-1:0]        mask_mem [DEPTH];
   logic [DRAM_ADDR_WIDTH-1:0] addr_mem [DEPTH];

   state_t             state_q, state_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic               row_done_q, row_done_d;

   logic               push, pop, rows_remain;
   logic [PTR_W-1:0]   rd_ptr_inc, wr_ptr_inc;
   logic [NUM_COLS-1:0] head_mask, next_mask;
   logic [NUM_BEATS-1:0] head_live, next_live;
   logic               later_found, first_found;
   logic [BEAT_W-1:0]  later_idx, first_idx;

   assign in_ready   = (occ_q < OCC_W'(DEPTH)) && n_rst;
   assign push       = in_valid && in_ready;
   assign rd_ptr_inc = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
   assign wr_ptr_inc = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
   assign occupancy  = occ_q;
   assign busy       = (occ_q != '0);
   assign row_done   = row_done_q;

   // Beat search: next live beat of the head row, and first live beat of the row that heads next
   always_comb begin
      head_mask   = mask_mem[rd_ptr_q];
      next_mask   = (occ_q > OCC_W'(1)) ? mask_mem[rd_ptr_inc] : in_col_mask;
      head_live   = '0;
      next_live   = '0;
      later_found = 1'b0;
      later_idx   = '0;
      first_found = 1'b0;
      first_idx   = '0;
      for (int b = NUM_BEATS - 1; b >= 0; b--) begin
         head_live[b] = (SKIP_EMPTY == 0) || (head_mask[b*BEAT_ELEMS +: BEAT_ELEMS] != '0);
         next_live[b] = (SKIP_EMPTY == 0) || (next_mask[b*BEAT_ELEMS +: BEAT_ELEMS] != '0);
         if (head_live[b] && (b > int'(beat_q))) begin
            later_found = 1'b1;
            later_idx   = BEAT_W'(b);
         end
         if (next_live[b]) begin
            first_found = 1'b1;
            first_idx   = BEAT_W'(b);
         end
      end
   end

   // Next state: beat advance, row pop and selection of the following row's first beat
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      pop         = 1'b0;
      rows_remain = (occ_q > OCC_W'(1)) || push;
      case (state_q)
         S_IDLE: begin
            if (push) begin
               state_d = first_found ? S_ISSUE : S_EMPTY_ROW;
               beat_d  = first_idx;
            end
         end
         S_ISSUE: begin
            if (dram_wready) begin
               if (later_found) beat_d = later_idx;
               else             pop    = 1'b1;
            end
         end
         S_EMPTY_ROW: pop = 1'b1;
         default: state_d = S_IDLE;
      endcase
      if (pop) begin
         if (rows_remain) begin
            state_d = first_found ? S_ISSUE : S_EMPTY_ROW;
            beat_d  = first_idx;
         end else begin
            state_d = S_IDLE;
            beat_d  = '0;
         end
      end
      rd_ptr_d   = pop  ? rd_ptr_inc : rd_ptr_q;
      wr_ptr_d   = push ? wr_ptr_inc : wr_ptr_q;
      occ_d      = occ_q + OCC_W'(push) - OCC_W'(pop);
      row_done_d = pop;
   end

   // Beat outputs are driven only while valid so idle/reset shows all zeros
   always_comb begin
      dram_wvalid = (state_q == S_ISSUE);
      dram_wlast  = dram_wvalid && !later_found;
      dram_waddr  = '0;
      dram_wdata  = '0;
      dram_wstrb  = '0;
      if (dram_wvalid) begin
         dram_waddr = addr_mem[rd_ptr_q] + DRAM_ADDR_WIDTH'(beat_q) * DRAM_ADDR_WIDTH'(BEAT_BYTES);
         for (int b = 0; b < NUM_BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
               dram_wdata = data_mem[rd_ptr_q][b*BEAT_DW +: BEAT_DW];
               dram_wstrb = head_mask[b*BEAT_ELEMS +: BEAT_ELEMS];
            end
         end
      end
   end

   // Control registers
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= S_IDLE;
         beat_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         occ_q      <= '0;
         row_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         occ_q      <= occ_d;
         row_done_q <= row_done_d;
      end
   end

   // Row storage; contents are don't-care until written, outputs are gated by wvalid
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= in_row_data;
         mask_mem[wr_ptr_q] <= in_col_mask;
         addr_mem[wr_ptr_q] <= in_dram_addr & ALIGN_MASK;
      end
   end

endmodule

// File: tb/tb_dram_write_packer.sv
// tb/tb_dram_write_packer.sv - scoreboard bench for dram_write_packer
module tb_dram_write_packer;

   typedef struct {
      logic [31:0] addr;
      logic [63:0] data;
      logic [3:0]  strb;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         n_rst;
   logic [1:0]   in_valid;
   logic [1:0]   in_ready;
   logic [511:0] in_row_data;
   logic [31:0]  in_col_mask;
   logic [31:0]  in_dram_addr;
   logic [1:0]   wr_mode;
   logic [1:0]   tog_q = 2'd0;
   logic         dram_wready;

   logic [1:0]   wvalid_w, wlast_w, row_done_w, busy_w;
   logic [31:0]  waddr_w [2];
   logic [63:0]  wdata_w [2];
   logic [3:0]   wstrb_w [2];
   logic [1:0]   occ_w [2];

   always @(posedge clk) tog_q <= tog_q + 2'd1;
   // mode 0: stalled, 1: always ready, 2: ready pattern 1,0,0,1
   assign dram_wready = (wr_mode == 2'd1) || ((wr_mode == 2'd2) && (tog_q == 2'd0 || tog_q == 2'd3));

   dram_write_packer #(.SKIP_EMPTY(0)) u_dut_noskip (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_row_data(in_row_data), .in_col_mask(in_col_mask), .in_dram_addr(in_dram_addr),
      .dram_wvalid(wvalid_w[0]), .dram_wready(dram_wready), .dram_waddr(waddr_w[0]),
      .dram_wdata(wdata_w[0]), .dram_wstrb(wstrb_w[0]), .dram_wlast(wlast_w[0]),
      .row_done(row_done_w[0]), .occupancy(occ_w[0]), .busy(busy_w[0]));

   dram_write_packer u_dut (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_row_data(in_row_data), .in_col_mask(in_col_mask), .in_dram_addr(in_dram_addr),
      .dram_wvalid(wvalid_w[1]), .dram_wready(dram_wready), .dram_waddr(waddr_w[1]),
      .dram_wdata(wdata_w[1]), .dram_wstrb(wstrb_w[1]), .dram_wlast(wlast_w[1]),
      .row_done(row_done_w[1]), .occupancy(occ_w[1]), .busy(busy_w[1]));

   int checks = 0;
   int failures = 0;
   beat_t q0[$];
   beat_t q1[$];
   int hs_cnt [2] = '{0, 0};
   int done_cnt [2] = '{0, 0};
   int idle_cnt = 0;
   logic [31:0] last_addr [2];
   logic [1:0]  held = 2'b00;
   logic [1:0]  prev_last = 2'b00;
   logic [31:0] hold_addr [2];
   logic [63:0] hold_data [2];
   logic [3:0]  hold_strb [2];
   logic [1:0]  hold_last;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] mk_row(input logic [7:0] s);
      logic [511:0] r;
      for (int k = 0; k < 32; k++) r[k*16 +: 16] = {s, 8'(k)};
      return r;
   endfunction

   // Expected beats for one row, derived from the mask and the skip setting of DUT d
   task automatic gen_expect(input int d, input logic [511:0] data, input logic [31:0] mask,
                             input logic [31:0] addr);
      beat_t tmp[$];
      beat_t b;
      for (int i = 0; i < 8; i++) begin
         b.strb = mask[i*4 +: 4];
         if (!(d == 1 && b.strb == 4'h0)) begin
            b.addr = (addr & 32'hFFFF_FFC0) + 32'(i * 8);
            b.data = data[i*64 +: 64];
            b.last = 1'b0;
            tmp.push_back(b);
         end
      end
      if (tmp.size() > 0) tmp[tmp.size()-1].last = 1'b1;
      foreach (tmp[i]) begin
         if (d == 0) q0.push_back(tmp[i]);
         else        q1.push_back(tmp[i]);
      end
   endtask

   // Monitor: pops the scoreboard on each handshake and checks stall stability
   always @(negedge clk) begin
      beat_t e;
      if (!n_rst) begin
         q0.delete();
         q1.delete();
         held = 2'b00;
         prev_last = 2'b00;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (row_done_w[d]) done_cnt[d]++;
            if (prev_last[d]) check($sformatf("row_done_after_wlast_%0d", d), row_done_w[d], 1);
            prev_last[d] = 1'b0;
            if (d == 1 && busy_w[1] && !wvalid_w[1]) idle_cnt++;
            if (wvalid_w[d]) begin
               if (held[d]) begin
                  check($sformatf("stall_addr_%0d", d), waddr_w[d], hold_addr[d]);
                  check($sformatf("stall_data_%0d", d), wdata_w[d], hold_data[d]);
                  check($sformatf("stall_strb_%0d", d), wstrb_w[d], hold_strb[d]);
                  check($sformatf("stall_last_%0d", d), wlast_w[d], hold_last[d]);
               end
               if (dram_wready) begin
                  hs_cnt[d]++;
                  last_addr[d] = waddr_w[d];
                  held[d] = 1'b0;
                  prev_last[d] = wlast_w[d];
                  check($sformatf("beat_expected_%0d", d), ((d == 0) ? q0.size() : q1.size()) > 0, 1);
                  if (((d == 0) ? q0.size() : q1.size()) > 0) begin
                     if (d == 0) e = q0.pop_front();
                     else        e = q1.pop_front();
                     check($sformatf("waddr_%0d", d), waddr_w[d], e.addr);
                     check($sformatf("wdata_%0d", d), wdata_w[d], e.data);
                     check($sformatf("wstrb_%0d", d), wstrb_w[d], e.strb);
                     check($sformatf("wlast_%0d", d), wlast_w[d], e.last);
                  end
               end else if (!held[d]) begin
                  held[d] = 1'b1;
                  hold_addr[d] = waddr_w[d];
                  hold_data[d] = wdata_w[d];
                  hold_strb[d] = wstrb_w[d];
                  hold_last[d] = wlast_w[d];
               end
            end else if (held[d]) begin
               check($sformatf("wvalid_held_in_stall_%0d", d), 0, 1);
               held[d] = 1'b0;
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the push edge
   task automatic push_row(input int d, input logic [511:0] data, input logic [31:0] mask,
                           input logic [31:0] addr);
      int n = 0;
      in_row_data = data;
      in_col_mask = mask;
      in_dram_addr = addr;
      in_valid[d] = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready[d] && n < 300);
      if (!in_ready[d]) check("push_accept_timeout", 0, 1);
      else gen_expect(d, data, mask, addr);
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while ((q0.size() != 0 || q1.size() != 0 || busy_w != 2'b00) && n < 400);
      check("drain_q0_empty", q0.size(), 0);
      check("drain_q1_empty", q1.size(), 0);
      check("drain_idle", busy_w, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int h, dn, h0, dn0, idl, n, gaps, accepted;
      logic [511:0] row_c;
      n_rst = 1'b0;
      in_valid = 2'b00;
      in_row_data = '0;
      in_col_mask = '0;
      in_dram_addr = '0;
      wr_mode = 2'd0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 2'b00);
      check("rst_wvalid", wvalid_w, 2'b00);
      check("rst_wlast", wlast_w, 2'b00);
      check("rst_row_done", row_done_w, 2'b00);
      check("rst_busy", busy_w, 2'b00);
      check("rst_occ", occ_w[1], 0);
      check("rst_waddr", waddr_w[1], 0);
      check("rst_wdata", wdata_w[1], 0);
      check("rst_wstrb", wstrb_w[1], 0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      wr_mode = 2'd1;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 2'b11);
      @(posedge clk);
      #1;

      // Full-mask row, unaligned base
      h = hs_cnt[1]; dn = done_cnt[1];
      push_row(1, mk_row(8'h11), 32'hFFFF_FFFF, 32'h1000_0047);
      @(negedge clk);
      check("t1_first_wvalid", wvalid_w[1], 1);
      check("t1_first_addr", waddr_w[1], 32'h1000_0040);
      @(posedge clk);
      #1;
      drain();
      check("t1_beats", hs_cnt[1] - h, 8);
      check("t1_row_done", done_cnt[1] - dn, 1);
      check("t1_last_addr", last_addr[1], 32'h1000_0078);

      // Sparse mask, with and without skipping
      h = hs_cnt[1]; dn = done_cnt[1];
      push_row(1, mk_row(8'h22), 32'h0000_F00F, 32'h2000_0000);
      drain();
      check("t2_skip_beats", hs_cnt[1] - h, 2);
      check("t2_skip_last_addr", last_addr[1], 32'h2000_0018);
      check("t2_skip_row_done", done_cnt[1] - dn, 1);
      h0 = hs_cnt[0]; dn0 = done_cnt[0];
      push_row(0, mk_row(8'h33), 32'h0000_F00F, 32'h2000_0100);
      drain();
      check("t2_noskip_beats", hs_cnt[0] - h0, 8);
      check("t2_noskip_last_addr", last_addr[0], 32'h2000_0138);
      check("t2_noskip_row_done", done_cnt[0] - dn0, 1);

      // Toggling backpressure
      wr_mode = 2'd2;
      h = hs_cnt[1]; dn = done_cnt[1];
      push_row(1, mk_row(8'h44), 32'hFFFF_FFFF, 32'h3000_0000);
      push_row(1, mk_row(8'h55), 32'hF0FF_FFFF, 32'h3000_0040);
      drain();
      check("t3_beats", hs_cnt[1] - h, 15);
      check("t3_row_done", done_cnt[1] - dn, 2);
      check("t3_last_addr", last_addr[1], 32'h3000_0078);

      // Fill under stall, then release
      wr_mode = 2'd0;
      dn = done_cnt[1];
      push_row(1, mk_row(8'h66), 32'hFFFF_FFFF, 32'h4000_0000);
      push_row(1, mk_row(8'h77), 32'hFFFF_FFFF, 32'h4000_0040);
      @(negedge clk);
      #1;
      check("t4_full_in_ready", in_ready[1], 0);
      check("t4_full_occ", occ_w[1], 2);
      @(posedge clk);
      #1;
      row_c = mk_row(8'h88);
      in_row_data = row_c;
      in_col_mask = 32'hFFFF_FFFF;
      in_dram_addr = 32'h4000_0080;
      in_valid[1] = 1'b1;
      wr_mode = 2'd1;
      h = hs_cnt[1]; gaps = 0; accepted = 0; n = 0;
      while ((hs_cnt[1] - h) < 24 && n < 300) begin
         @(negedge clk);
         #1;
         n++;
         if (!wvalid_w[1]) gaps++;
         if (accepted == 1) begin
            in_valid[1] = 1'b0;
            accepted = 2;
         end else if (accepted == 0 && in_ready[1]) begin
            check("t4_third_push_at_row_done", row_done_w[1], 1);
            gen_expect(1, row_c, 32'hFFFF_FFFF, 32'h4000_0080);
            accepted = 1;
         end
      end
      in_valid[1] = 1'b0;
      check("t4_beats", hs_cnt[1] - h, 24);
      check("t4_no_bubble", gaps, 0);
      check("t4_third_accepted", accepted, 2);
      @(posedge clk);
      #1;
      drain();
      check("t4_row_done", done_cnt[1] - dn, 3);

      // Fully masked row between two full rows
      h = hs_cnt[1]; dn = done_cnt[1]; idl = idle_cnt;
      push_row(1, mk_row(8'h99), 32'hFFFF_FFFF, 32'h5000_0000);
      push_row(1, mk_row(8'hAA), 32'h0000_0000, 32'h5000_0040);
      push_row(1, mk_row(8'hBB), 32'hFFFF_FFFF, 32'h5000_0080);
      drain();
      check("t5_beats", hs_cnt[1] - h, 16);
      check("t5_row_done", done_cnt[1] - dn, 3);
      check("t5_idle_cycles", idle_cnt - idl, 1);
      check("t5_last_addr", last_addr[1], 32'h5000_00B8);

      // Reset in the middle of a row with a second row queued
      dn = done_cnt[1];
      push_row(1, mk_row(8'hCC), 32'hFFFF_FFFF, 32'h6000_0000);
      push_row(1, mk_row(8'hDD), 32'hFFFF_FFFF, 32'h6000_0040);
      n = 0;
      while (!(wvalid_w[1] && waddr_w[1] == 32'h6000_0020) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("t6_reached_beat4", waddr_w[1], 32'h6000_0020);
      n_rst = 1'b0;
      wr_mode = 2'd0;
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      wr_mode = 2'd1;
      @(negedge clk);
      #1;
      check("t6_wvalid", wvalid_w[1], 0);
      check("t6_occ", occ_w[1], 0);
      check("t6_row_done", row_done_w[1], 0);
      check("t6_busy", busy_w[1], 0);
      check("t6_in_ready", in_ready[1], 1);
      check("t6_no_retire", done_cnt[1] - dn, 0);
      @(posedge clk);
      #1;
      h = hs_cnt[1]; dn = done_cnt[1];
      push_row(1, mk_row(8'hEE), 32'hFFFF_FFFF, 32'h6000_0100);
      @(negedge clk);
      #1;
      check("t6_new_first_addr", waddr_w[1], 32'h6000_0100);
      check("t6_new_first_strb", wstrb_w[1], 4'hF);
      @(posedge clk);
      #1;
      drain();
      check("t6_new_beats", hs_cnt[1] - h, 8);
      check("t6_new_row_done", done_cnt[1] - dn, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
